// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the sequence-detector sequencing controller.
package seq_det_pkg;

  localparam int WORD_W_DEF    = 8;
  localparam int CNT_W_DEF     = 4;
  localparam int DRAIN_CYC_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [31:0] MAX_VAL = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), MAX_VAL));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Frames each accepted word with det_start_o, shifts it into the detector and counts hits.
// Build option SEQ_DET_CTRL_LSB_FIRST_EN: serialise LSB first instead of MSB first.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  input  logic [WORD_W-1:0] word_i,
  input  logic              abort_i,
  output logic              det_start_o,
  output logic              det_serial_o,
  input  logic              det_detected_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [CNT_W-1:0]  res_count_o,
  output logic              res_hit_o,
  output logic              busy_o
);

  localparam int BW = $clog2(WORD_W);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              cnt_clr, cnt_inc;
  logic [CNT_W-1:0]  match_cnt;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    drain_d      = drain_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    word_ready_o = 1'b0;
    det_start_o  = 1'b0;
    det_serial_o = 1'b0;
    res_valid_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        word_ready_o = 1'b1;
        if (word_valid_i) begin
          shift_d = word_i;
          cnt_clr = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        det_start_o = 1'b1;
        bit_d       = BW'(WORD_W - 1);
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        det_start_o = 1'b1;
        cnt_inc     = det_detected_i;
`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
        det_serial_o = shift_q[0];
        shift_d      = shift_q >> 1;
`else
        det_serial_o = shift_q[WORD_W-1];
        shift_d      = shift_q << 1;
`endif
        if (bit_q == '0) begin
          drain_d = DW'(DRAIN_CYC - 1);
          state_d = S_DRAIN;
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end
      S_DRAIN: begin
        // Detector output lags the last bit; keep start high and keep counting.
        det_start_o = 1'b1;
        cnt_inc     = det_detected_i;
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      shift_d = '0;
      bit_d   = '0;
      drain_d = '0;
      cnt_clr = 1'b1;
      cnt_inc = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      drain_q <= drain_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (match_cnt)
  );

  assign res_count_o = res_valid_o ? match_cnt : '0;
  assign res_hit_o   = |res_count_o;
  assign busy_o      = (state_q != S_IDLE);

endmodule
